wb_regfile_stage: RTL and testbench

- Writeback stage of the RV32i 5-stage pipeline. It is the consumer end of the MEM/WB pipeline register.
- Selects the final result, writes it into the 32x32 architectural register file, and serves the decode stage's two combinational read ports.
- Exports Result_W to the hazard/forwarding logic.
- Keeps a 64-bit retired-instruction counter for instret.

---
 rtl/wb_regfile_stage_pkg.sv | 25 ++
 rtl/wb_regfile_stage_register_file.sv | 51 +++++
 rtl/wb_regfile_stage.sv | 73 +++++++
 tb/tb_wb_regfile_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_stage_pkg.sv
// Shared definitions for the writeback stage: widths, result-select
// encodings and the register-file write-port payload.
package wb_regfile_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned CNT_W      = 64;

  // Result_Src_Sel encodings; 2'b11 is reserved and falls back to the ALU.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } res_sel_e;

  // Qualified write request into the register file.
  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_port_t;

endpackage : wb_regfile_stage_pkg

// File: rtl/wb_regfile_stage_register_file.sv
// 32x32 architectural register file: one synchronous write port, two
// asynchronous read ports, x0 hardwired to zero.
// Optional macro WB_BYPASS_EN: a read of the index being written this cycle
// returns the incoming write data instead of the stored (old) value.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears all registers)
//   wr           qualified write request (en already includes Valid_W)
//   rs1, rs2     read addresses
//   rd1_c, rd2_c combinational read data
module wb_regfile_stage_register_file
  import wb_regfile_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  wr_port_t              wr,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]       rd1_c,
  output logic [XLEN-1:0]       rd2_c
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  // Storage and write port; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr.en && (wr.addr != '0)) begin
      regs_q[wr.addr] <= wr.data;
    end
  end

  // Read port 1.
  always_comb begin
    rd1_c = (rs1 == '0) ? '0 : regs_q[rs1];
`ifdef WB_BYPASS_EN
    if (wr.en && (wr.addr != '0) && (rs1 == wr.addr)) rd1_c = wr.data;
`endif
  end

  // Read port 2.
  always_comb begin
    rd2_c = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef WB_BYPASS_EN
    if (wr.en && (wr.addr != '0) && (rs2 == wr.addr)) rd2_c = wr.data;
`endif
  end

endmodule : wb_regfile_stage_register_file

// File: rtl/wb_regfile_stage.sv
// RV32I writeback stage: selects the final result, writes it into the
// register file, serves decode's two read ports and counts retired
// instructions. Optional macro WB_BYPASS_EN enables write-through reads.
// Ports:
//   CLK, RST_N                clock, async active-low reset
//   REG_W_En_W, Valid_W       write enable / real-instruction qualifier
//   Result_Src_Sel_W, RD_W    result select, destination index
//   Data_Out_Ext_W, ALU_Out_W, PC_Plus_4_W  result candidates
//   RS1_D, RS2_D / RD1_D, RD2_D             decode read ports (combinational)
//   Result_W                  selected result (combinational, to forwarding)
//   Instret                   retired-instruction counter
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REG_W_En_W,
  input  logic [1:0]            Result_Src_Sel_W,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic [XLEN-1:0]       Data_Out_Ext_W,
  input  logic [XLEN-1:0]       ALU_Out_W,
  input  logic [XLEN-1:0]       PC_Plus_4_W,
  input  logic                  Valid_W,
  input  logic [REG_ADDR_W-1:0] RS1_D,
  input  logic [REG_ADDR_W-1:0] RS2_D,
  output logic [XLEN-1:0]       RD1_D,
  output logic [XLEN-1:0]       RD2_D,
  output logic [XLEN-1:0]       Result_W,
  output logic [CNT_W-1:0]      Instret
);

  logic [CNT_W-1:0] instret_q;
  wr_port_t         wr;

  // Result select; the reserved code behaves as ALU.
  always_comb begin
    Result_W = ALU_Out_W;
    case (res_sel_e'(Result_Src_Sel_W))
      RES_MEM: Result_W = Data_Out_Ext_W;
      RES_PC4: Result_W = PC_Plus_4_W;
      default: Result_W = ALU_Out_W;
    endcase
  end

  // Bubbles never write.
  always_comb begin
    wr.en   = REG_W_En_W & Valid_W;
    wr.addr = RD_W;
    wr.data = Result_W;
  end

  wb_regfile_stage_register_file u_rf (
    .clk   (CLK),
    .rst_n (RST_N),
    .wr    (wr),
    .rs1   (RS1_D),
    .rs2   (RS2_D),
    .rd1_c (RD1_D),
    .rd2_c (RD2_D)
  );

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instret_q <= '0;
    end else if (Valid_W) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign Instret = instret_q;

endmodule : wb_regfile_stage

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed scenarios followed by
// random traffic, all checked against an array-based reference model.
module tb_wb_regfile_stage;
  import wb_regfile_stage_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  reg_w_en;
  logic [1:0]            sel;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       mem_d;
  logic [XLEN-1:0]       alu_d;
  logic [XLEN-1:0]       pc4_d;
  logic                  valid;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [XLEN-1:0]       rd1;
  logic [XLEN-1:0]       rd2;
  logic [XLEN-1:0]       result;
  logic [CNT_W-1:0]      instret;

  wb_regfile_stage u_dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .REG_W_En_W       (reg_w_en),
    .Result_Src_Sel_W (sel),
    .RD_W             (rd),
    .Data_Out_Ext_W   (mem_d),
    .ALU_Out_W        (alu_d),
    .PC_Plus_4_W      (pc4_d),
    .Valid_W          (valid),
    .RS1_D            (rs1),
    .RS2_D            (rs2),
    .RD1_D            (rd1),
    .RD2_D            (rd2),
    .Result_W         (result),
    .Instret          (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [XLEN-1:0]  m_regs [32];
  logic [CNT_W-1:0] m_instret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instret = '0;
  endtask

  function automatic logic [XLEN-1:0] exp_result();
    case (sel)
      2'd1:    return mem_d;
      2'd2:    return pc4_d;
      default: return alu_d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    if (reg_w_en && valid && rd != 5'd0 && idx == rd) return exp_result();
`endif
    return m_regs[idx];
  endfunction

  // One pipeline cycle: drive after the falling edge, check combinational
  // outputs mid-cycle, then apply the architectural effect of the edge.
  task automatic step(input logic en, input logic [1:0] s, input logic [4:0] d,
                      input logic [31:0] m, input logic [31:0] a, input logic [31:0] p,
                      input logic v, input logic [4:0] r1, input logic [4:0] r2);
    logic [XLEN-1:0] res;
    @(negedge clk);
    reg_w_en = en; sel = s; rd = d; mem_d = m; alu_d = a; pc4_d = p;
    valid = v; rs1 = r1; rs2 = r2;
    #1;
    res = exp_result();
    chk("result", 64'(result), 64'(res));
    chk("rd1", 64'(rd1), 64'(exp_read(r1)));
    chk("rd2", 64'(rd2), 64'(exp_read(r2)));
    chk("instret", instret, m_instret);
    @(posedge clk);
    if (en && v && d != 5'd0) m_regs[d] = res;
    if (v) m_instret = m_instret + 64'd1;
  endtask

  task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, r1, r2);
  endtask

  initial begin
    rst_n = 1'b0; reg_w_en = 1'b0; sel = 2'd0; rd = '0; mem_d = '0;
    alu_d = '0; pc4_d = '0; valid = 1'b0; rs1 = '0; rs2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Populate some registers, then reset in the middle of a pending write.
    step(1'b1, 2'd0, 5'd4, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 5'd4, 5'd0);
    step(1'b1, 2'd0, 5'd31, 32'h0, 32'h8765_4321, 32'h0, 1'b1, 5'd4, 5'd31);
    @(negedge clk);
    reg_w_en = 1'b1; valid = 1'b1; rd = 5'd4; sel = 2'd0; alu_d = 32'hFFFF_0000;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk("reset_rd1", 64'(rd1), 64'd0);
      chk("reset_rd2", 64'(rd2), 64'd0);
    end
    chk("reset_instret", instret, 64'd0);
    @(negedge clk);
    reg_w_en = 1'b0; valid = 1'b0;
    rst_n = 1'b1;

    // x0 stays zero.
    step(1'b1, 2'd0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd0, 5'd0);
    idle_read(5'd0, 5'd0);
    chk("x0_read", 64'(rd1), 64'd0);

    // Result mux into x5 for every select code.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 2'(s), 5'd5, 32'h22, 32'h11, 32'h33, 1'b1, 5'd1, 5'd2);
      idle_read(5'd5, 5'd5);
      chk("mux_x5", 64'(rd1), (s == 1) ? 64'h22 : (s == 2) ? 64'h33 : 64'h11);
    end

    // Bubble must not write or retire.
    step(1'b1, 2'd0, 5'd7, 32'h55, 32'h55, 32'h55, 1'b0, 5'd7, 5'd7);
    idle_read(5'd7, 5'd0);
    chk("bubble_x7", 64'(rd1), 64'd0);

    // Same-cycle write/read of x3; the model handles both bypass variants.
    step(1'b1, 2'd0, 5'd3, 32'h0, 32'hCAFE_0000, 32'h0, 1'b1, 5'd3, 5'd3);
    idle_read(5'd3, 5'd3);
    chk("hazard_next", 64'(rd2), 64'hCAFE_0000);

    // Back-to-back writes to x9.
    step(1'b1, 2'd0, 5'd9, 32'h0, 32'h1, 32'h0, 1'b1, 5'd9, 5'd0);
    step(1'b1, 2'd0, 5'd9, 32'h0, 32'h2, 32'h0, 1'b1, 5'd9, 5'd0);
    chk("b2b_first", 64'(rd1), 64'h1);
    idle_read(5'd9, 5'd9);
    chk("b2b_second", 64'(rd1), 64'h2);

    // Instret counts ten retirements from reset regardless of write enable.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'(i % 2), 2'd0, 5'(i + 10), 32'h0, 32'(i), 32'h0, 1'b1, 5'd0, 5'd0);
    end
    idle_read(5'd0, 5'd0);
    chk("instret_10", instret, 64'd10);

    // Counter wrap from all ones.
    @(negedge clk);
    force u_dut.instret_q = '1;
    #1;
    release u_dut.instret_q;
    #1;
    if (instret === '1) begin
      m_instret = '1;
      step(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0);
      idle_read(5'd0, 5'd0);
      chk("instret_wrap", instret, 64'd0);
    end else begin
      $display("note: counter preload not retained, wrap step skipped");
      m_instret = instret;
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), d,
           32'($urandom), 32'($urandom), 32'($urandom),
           1'($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) == 0) ? d : 5'($urandom),
           ($urandom_range(0, 2) == 0) ? d : 5'($urandom));
    end
    for (int i = 0; i < 32; i += 2) idle_read(5'(i), 5'(i + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_wb_regfile_stage
